// File: rtl/alu_issue.sv
// ALU issue stage: decodes an RV32I instruction into ALU op/operands and holds the
// decoded result in a two-entry skid buffer (main drives the ALU, skid absorbs a stall).
module alu_issue (
   input  logic        clk,
   input  logic        rstn,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_inst,
   input  logic [31:0] in_pc,
   input  logic [31:0] in_rs1_val,
   input  logic [31:0] in_rs2_val,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [4:0]  alu_op,
   output logic [31:0] alu_src0,
   output logic [31:0] alu_src1,
   output logic        out_illegal
);

   localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_SLT  = 5'd2,  OP_SLTU = 5'd3,
                          OP_AND  = 5'd4,  OP_OR   = 5'd5,  OP_XOR  = 5'd6,  OP_SLL  = 5'd7,
                          OP_SRL  = 5'd8,  OP_SRA  = 5'd9,  OP_SRC0 = 5'd10, OP_SRC1 = 5'd11;

   localparam logic [6:0] OPC_OP     = 7'b0110011, OPC_OP_IMM = 7'b0010011,
                          OPC_LUI    = 7'b0110111, OPC_AUIPC  = 7'b0010111,
                          OPC_JAL    = 7'b1101111, OPC_JALR   = 7'b1100111,
                          OPC_LOAD   = 7'b0000011, OPC_STORE  = 7'b0100011,
                          OPC_BRANCH = 7'b1100011;

   typedef struct packed {
      logic [4:0]  op;
      logic [31:0] src0;
      logic [31:0] src1;
      logic        illegal;
   } entry_t;

   // Shared funct3 mapping of OP / OP-IMM; alt selects SUB or SRA.
   function automatic logic [4:0] alu_fn(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  alu_fn = alt ? OP_SUB : OP_ADD;
         3'b001:  alu_fn = OP_SLL;
         3'b010:  alu_fn = OP_SLT;
         3'b011:  alu_fn = OP_SLTU;
         3'b100:  alu_fn = OP_XOR;
         3'b101:  alu_fn = alt ? OP_SRA : OP_SRL;
         3'b110:  alu_fn = OP_OR;
         default: alu_fn = OP_AND;
      endcase
   endfunction

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] imm_i, imm_s, imm_u;
   entry_t      dec;

   assign opcode = in_inst[6:0];
   assign funct3 = in_inst[14:12];
   assign funct7 = in_inst[31:25];
   assign imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
   assign imm_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
   assign imm_u  = {in_inst[31:12], 12'b0};

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      dec = '{op: OP_ADD, src0: 32'd0, src1: 32'd0, illegal: 1'b0};
      case (opcode)
         OPC_OP: begin
            if (funct7 == 7'h00 || (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
               dec.op   = alu_fn(funct3, funct7[5]);
               dec.src0 = in_rs1_val;
               dec.src1 = in_rs2_val;
            end else begin
               dec.illegal = 1'b1;
            end
         end
         OPC_OP_IMM: begin
            dec.op   = alu_fn(funct3, funct3 == 3'b101 && in_inst[30]);
            dec.src0 = in_rs1_val;
            dec.src1 = (funct3 == 3'b001 || funct3 == 3'b101) ? {27'd0, in_inst[24:20]} : imm_i;
         end
         OPC_LUI: begin
            dec.op   = OP_SRC1;
            dec.src1 = imm_u;
         end
         OPC_AUIPC: begin
            dec.src0 = in_pc;
            dec.src1 = imm_u;
         end
         OPC_JAL, OPC_JALR: begin
            dec.src0 = in_pc;
            dec.src1 = 32'd4;
         end
         OPC_LOAD: begin
            dec.src0 = in_rs1_val;
            dec.src1 = imm_i;
         end
         OPC_STORE: begin
            dec.src0 = in_rs1_val;
            dec.src1 = imm_s;
         end
         OPC_BRANCH: begin
            if (funct3[2:1] == 2'b01) begin
               dec.illegal = 1'b1;
            end else begin
               dec.op   = (funct3[2:1] == 2'b00) ? OP_SUB : (funct3[1] ? OP_SLTU : OP_SLT);
               dec.src0 = in_rs1_val;
               dec.src1 = in_rs2_val;
            end
         end
         default: dec.illegal = 1'b1;
      endcase
   end

   entry_t main_q, main_d, skid_q, skid_d;
   logic   main_valid_q, main_valid_d, skid_valid_q, skid_valid_d, in_ready_q;
   logic   in_fire, out_fire;

   assign in_fire  = in_valid && in_ready_q;
   assign out_fire = main_valid_q && out_ready;

   always_comb begin
      main_d       = main_q;
      main_valid_d = main_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (out_fire || !main_valid_q) begin
         // Main slot is free this cycle: refill from skid first to keep order.
         if (skid_valid_q) begin
            main_d       = skid_q;
            skid_valid_d = 1'b0;
         end else begin
            main_d       = dec;
            main_valid_d = in_fire;
         end
      end else if (in_fire) begin
         skid_d       = dec;
         skid_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only; blocking is for always_comb.
      if (!rstn) begin
         main_q       <= '{op: OP_ADD, src0: 32'd0, src1: 32'd0, illegal: 1'b0};
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
      end else begin
         main_q       <= main_d;
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= !skid_valid_d;
      end
   end

   // NOTE: skid payload is never observed unless skid_valid_q is set, so it carries no reset.
   always_ff @(posedge clk) begin
      skid_q <= skid_d;
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = main_valid_q;
   assign alu_op      = main_q.op;
   assign alu_src0    = main_q.src0;
   assign alu_src1    = main_q.src1;
   assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: table of decode vectors plus hand-written
// stall, flush and reset sequences. Inputs change and outputs are sampled on negedge.
module tb_alu_issue;

   localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, SLT = 5'd2, SLTU = 5'd3, AND_ = 5'd4,
                          OR_ = 5'd5, XOR_ = 5'd6, SLL = 5'd7, SRL = 5'd8, SRA = 5'd9,
                          SRC1 = 5'd11;

   logic        clk, rstn, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
   logic [31:0] in_inst, in_pc, in_rs1_val, in_rs2_val, alu_src0, alu_src1;
   logic [4:0]  alu_op;

   int n_checks = 0;
   int n_errors = 0;

   alu_issue dut (
      .clk(clk), .rstn(rstn), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
      .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
      .out_valid(out_valid), .out_ready(out_ready),
      .alu_op(alu_op), .alu_src0(alu_src0), .alu_src1(alu_src1), .out_illegal(out_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] inst, pc, rs1, rs2;
      logic [4:0]  op;
      logic [31:0] src0, src1;
      logic        ill;
   } vec_t;

   vec_t vecs[24];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic check_out(input string name, input logic [4:0] op, input logic [31:0] s0,
                            input logic [31:0] s1, input logic ill);
      check({name, ".valid"}, {31'd0, out_valid}, 32'd1);
      check({name, ".op"}, {27'd0, alu_op}, {27'd0, op});
      check({name, ".src0"}, alu_src0, s0);
      check({name, ".src1"}, alu_src1, s1);
      check({name, ".ill"}, {31'd0, out_illegal}, {31'd0, ill});
   endtask

   task automatic check_reset_vals(input string name);
      check({name, ".valid"}, {31'd0, out_valid}, 32'd0);
      check({name, ".ready"}, {31'd0, in_ready}, 32'd1);
      check({name, ".op"}, {27'd0, alu_op}, {27'd0, ADD});
      check({name, ".src0"}, alu_src0, 32'd0);
      check({name, ".src1"}, alu_src1, 32'd0);
      check({name, ".ill"}, {31'd0, out_illegal}, 32'd0);
   endtask

   task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] rs1,
                        input logic [31:0] rs2);
      in_valid   = 1'b1;
      in_inst    = inst;
      in_pc      = pc;
      in_rs1_val = rs1;
      in_rs2_val = rs2;
   endtask

   initial begin
      //            inst          pc            rs1           rs2           op    src0          src1          ill
      vecs[0]  = '{32'hFFF10093, 32'h0,        32'd5,        32'd0,        ADD,  32'd5,        32'hFFFFFFFF, 1'b0}; // addi -1
      vecs[1]  = '{32'h002081B3, 32'h0,        32'd10,       32'd20,       ADD,  32'd10,       32'd20,       1'b0}; // add
      vecs[2]  = '{32'h402081B3, 32'h0,        32'd11,       32'd21,       SUB,  32'd11,       32'd21,       1'b0}; // sub
      vecs[3]  = '{32'h0020A1B3, 32'h0,        32'd12,       32'd22,       SLT,  32'd12,       32'd22,       1'b0}; // slt
      vecs[4]  = '{32'h4020D1B3, 32'h0,        32'h80000000, 32'd4,        SRA,  32'h80000000, 32'd4,        1'b0}; // sra
      vecs[5]  = '{32'h0020F1B3, 32'h0,        32'hF0F0F0F0, 32'h0FF00FF0, AND_, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0}; // and
      vecs[6]  = '{32'h0020C1B3, 32'h0,        32'd1,        32'd2,        XOR_, 32'd1,        32'd2,        1'b0}; // xor
      vecs[7]  = '{32'h40315093, 32'h0,        32'd64,       32'd0,        SRA,  32'd64,       32'd3,        1'b0}; // srai 3
      vecs[8]  = '{32'h00711093, 32'h0,        32'd9,        32'd0,        SLL,  32'd9,        32'd7,        1'b0}; // slli 7
      vecs[9]  = '{32'h00315093, 32'h0,        32'd9,        32'd0,        SRL,  32'd9,        32'd3,        1'b0}; // srli 3
      vecs[10] = '{32'h0F016093, 32'h0,        32'd3,        32'd0,        OR_,  32'd3,        32'h000000F0, 1'b0}; // ori
      vecs[11] = '{32'hFFF13093, 32'h0,        32'd7,        32'd0,        SLTU, 32'd7,        32'hFFFFFFFF, 1'b0}; // sltiu -1
      vecs[12] = '{32'h123450B7, 32'h40,       32'd99,       32'd98,       SRC1, 32'd0,        32'h12345000, 1'b0}; // lui
      vecs[13] = '{32'h00001097, 32'h100,      32'd99,       32'd98,       ADD,  32'h100,      32'h1000,     1'b0}; // auipc
      vecs[14] = '{32'h008000EF, 32'h200,      32'd99,       32'd98,       ADD,  32'h200,      32'd4,        1'b0}; // jal
      vecs[15] = '{32'h000080E7, 32'h300,      32'd99,       32'd98,       ADD,  32'h300,      32'd4,        1'b0}; // jalr
      vecs[16] = '{32'hFFC12083, 32'h0,        32'h1000,     32'd0,        ADD,  32'h1000,     32'hFFFFFFFC, 1'b0}; // lw -4
      vecs[17] = '{32'hFE20AC23, 32'h0,        32'h2000,     32'd5,        ADD,  32'h2000,     32'hFFFFFFF8, 1'b0}; // sw -8
      vecs[18] = '{32'h00208063, 32'h0,        32'd30,       32'd31,       SUB,  32'd30,       32'd31,       1'b0}; // beq
      vecs[19] = '{32'h0020D063, 32'h0,        32'd32,       32'd33,       SLT,  32'd32,       32'd33,       1'b0}; // bge
      vecs[20] = '{32'h0020E063, 32'h0,        32'd34,       32'd35,       SLTU, 32'd34,       32'd35,       1'b0}; // bltu
      vecs[21] = '{32'h0000007F, 32'h50,       32'd1,        32'd2,        ADD,  32'd0,        32'd0,        1'b1}; // bad opcode
      vecs[22] = '{32'h0020A063, 32'h0,        32'd1,        32'd2,        ADD,  32'd0,        32'd0,        1'b1}; // branch f3=010
      vecs[23] = '{32'h022081B3, 32'h0,        32'd1,        32'd2,        ADD,  32'd0,        32'd0,        1'b1}; // op funct7=1

      rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_inst = 32'd0; in_pc = 32'd0; in_rs1_val = 32'd0; in_rs2_val = 32'd0;
      repeat (2) @(negedge clk);
      check_reset_vals("reset");
      rstn = 1'b1;

      // Single-entry latency: accepted at posedge, visible on the next negedge.
      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].inst, vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
         @(negedge clk);
         in_valid = 1'b0;
         check_out($sformatf("vec%0d", i), vecs[i].op, vecs[i].src0, vecs[i].src1, vecs[i].ill);
      end
      @(negedge clk);
      check("drain.valid", {31'd0, out_valid}, 32'd0);

      // Back-to-back SRAI then LUI at full throughput.
      drive(32'h40315093, 32'h0, 32'd77, 32'd0);
      @(negedge clk);
      check_out("b2b.srai", SRA, 32'd77, 32'd3, 1'b0);
      drive(32'h123450B7, 32'h0, 32'd0, 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      check_out("b2b.lui", SRC1, 32'd0, 32'h12345000, 1'b0);
      check("b2b.ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);

      // Stall: three offers with out_ready low, only two may be taken.
      out_ready = 1'b0;
      drive(32'hFFF10093, 32'h0, 32'd1, 32'd0);
      @(negedge clk);
      drive(32'hFFF10093, 32'h0, 32'd2, 32'd0);
      @(negedge clk);
      check("stall.ready_full", {31'd0, in_ready}, 32'd0);
      drive(32'hFFF10093, 32'h0, 32'd3, 32'd0);
      @(negedge clk);
      check_out("stall.hold", ADD, 32'd1, 32'hFFFFFFFF, 1'b0);
      check("stall.still_full", {31'd0, in_ready}, 32'd0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check_out("stall.second", ADD, 32'd2, 32'hFFFFFFFF, 1'b0);
      check("stall.ready_back", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      check("stall.no_third", {31'd0, out_valid}, 32'd0);

      // Flush with both entries held and a same-cycle offer.
      out_ready = 1'b0;
      drive(32'h123450B7, 32'h0, 32'd0, 32'd0);
      @(negedge clk);
      drive(32'h00001097, 32'h10, 32'd0, 32'd0);
      @(negedge clk);
      check("flush.pre_full", {31'd0, in_ready}, 32'd0);
      flush = 1'b1;
      drive(32'h002081B3, 32'h0, 32'd4, 32'd5);
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      check("flush.valid", {31'd0, out_valid}, 32'd0);
      check("flush.ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      check("flush.dropped", {31'd0, out_valid}, 32'd0);

      // Reset in the middle of a stall discards everything.
      drive(32'h123450B7, 32'h0, 32'd0, 32'd0);
      @(negedge clk);
      drive(32'h40315093, 32'h0, 32'd8, 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      check_out("midrst.pre", SRC1, 32'd0, 32'h12345000, 1'b0);
      rstn = 1'b0;
      @(negedge clk);
      check_reset_vals("midrst");
      rstn = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      check("midrst.after", {31'd0, out_valid}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32; op codes SHALL be the shared ALU op macros (ADD, SUB, SLT, SLTU, AND, OR, XOR, SLL, SRL, SRA, SRC0, SRC1), 5 bits wide.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rstn  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 flush  input  1  synchronous discard of all buffered entries.
REQ-005 in_valid  input  1  ID stage presents an instruction.
REQ-006 in_ready  output  1  block can accept an instruction this cycle.
REQ-007 in_inst  input  32  RV32I instruction word.
REQ-008 in_pc  input  32  instruction PC.
REQ-009 in_rs1_val / in_rs2_val  input  32 each  register operand values, already forwarded.
REQ-010 out_valid  output  1  EX-side entry valid.
REQ-011 out_ready  input  1  ALU/EX stage consumes the entry.
REQ-012 alu_op  output  5  op code that drives the ALU.
REQ-013 alu_src0 / alu_src1  output  32 each  ALU operands.
REQ-014 out_illegal  output  1  entry holds an undecodable instruction.

Function
REQ-015 Decode SHALL occur combinationally on the input side; decoded op, src0, src1 and illegal flag SHALL be stored, not the raw instruction.
REQ-016 OP (0110011): src0=rs1, src1=rs2; funct3 000 -> ADD (funct7[5]=0) or SUB (funct7[5]=1); 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL/SRA by funct7[5]; 110 OR; 111 AND.
REQ-017 OP-IMM (0010011): src0=rs1, src1=sign-extended I-immediate; same funct3 mapping, with SUB never produced; 101 SRA only when inst[30]=1; for 001/101, src1 = zero-extended shamt inst[24:20].
REQ-018 LUI: op SRC1, src0=0, src1={inst[31:12],12'b0}. AUIPC: op ADD, src0=pc, src1={inst[31:12],12'b0}.
REQ-019 JAL/JALR: op ADD, src0=pc, src1=4 (link value).
REQ-020 LOAD: op ADD, src0=rs1, src1=sign-extended I-imm. STORE: op ADD, src0=rs1, src1=sign-extended S-imm.
REQ-021 BRANCH: src0=rs1, src1=rs2; funct3 000/001 -> SUB; 100/101 -> SLT; 110/111 -> SLTU; 010/011 illegal.
REQ-022 Any other opcode, or OP with funct7 not in {0000000, 0100000} or funct7=0100000 with funct3 not 000/101: out_illegal=1, alu_op=ADD, src0=0, src1=0.
REQ-023 Storage SHALL be a 2-entry skid buffer (main + skid); in_ready SHALL be a registered signal equal to "skid entry empty".
REQ-024 Transfer in occurs when in_valid & in_ready; transfer out when out_valid & out_ready.
REQ-025 Latency: an accepted instruction SHALL appear on the outputs the cycle after acceptance when the buffer was empty.
REQ-026 Order SHALL be preserved; outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-027 Simultaneous in/out transfer with one entry held: new entry replaces main, skid stays empty, throughput one per cycle.
REQ-028 Full (both entries held): in_ready=0; in_valid is ignored; one out transfer moves skid to main and sets in_ready=1 next cycle.
REQ-029 flush=1 SHALL empty both entries next cycle and drop any same-cycle input; flush has priority over all transfers.

Reset
REQ-030 While rstn=0 at a clock edge: both entries invalid, out_valid=0, in_ready=1, alu_op=ADD, alu_src0=0, alu_src1=0, out_illegal=0.
REQ-031 Reset SHALL have priority over flush and transfers; an entry held mid-stall is discarded.

Verification
REQ-032 ADDI x1,x2,-1 (0xFFF10093), rs1=5, out_ready=1 -> next cycle out_valid=1, alu_op=ADD, src0=5, src1=0xFFFFFFFF, illegal=0.
REQ-033 SRAI (inst[30]=1, shamt 3) then LUI 0x12345 back-to-back -> alu_op SRA src1=3, then SRC1 src1=0x12345000, one per cycle.
REQ-034 out_ready=0, three valid inputs -> first two accepted, in_ready=0 on third; release -> outputs in order, no loss or duplicate.
REQ-035 Opcode 0x7F, then BRANCH funct3=010 -> out_illegal=1, op ADD, srcs 0, both cases.
REQ-036 Two entries held, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1; rstn=0 mid-stall -> REQ-030 values.
